// File: rtl/i2s_frame_ctrl_if.sv
// Bundle of I2S timing outputs and consumer handshake signals for i2s_frame_ctrl.
// master = the frame controller, slave = receiver/consumer side.
interface i2s_frame_ctrl_if;
    logic       en;
    logic       sck;
    logic       ws;
    logic       sample;
    logic [5:0] frame_posn;
    logic       sof;
    logic       ready;
    logic       valid;
    logic       ack;
    logic       overrun;
    logic       clr_ovr;

    modport master (
        input  en, ack, clr_ovr,
        output sck, ws, sample, frame_posn, sof, ready, valid, overrun
    );

    modport slave (
        output en, ack, clr_ovr,
        input  sck, ws, sample, frame_posn, sof, ready, valid, overrun
    );
endinterface

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame timing: sck divider, word select, frame position, sample/sof/ready strobes,
// plus valid/ack handshake with sticky overrun for each completed stereo word.
//
// state | meaning
// IDLE  | outputs quiet, divider and frame position held at 0
// RUN   | free-running 64-bit frames
// DRAIN | en dropped; finish the current frame, then IDLE
module i2s_frame_ctrl #(
    parameter int DIV  = 8,
    parameter int BITS = 16
) (
    input  logic               ck,
    input  logic               rst_n,
    i2s_frame_ctrl_if.master   bus
);
    localparam int             DW        = $clog2(DIV);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF  = DW'(DIV / 2);
    localparam logic [5:0]     EOW_RIGHT = 6'(33 + BITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [5:0]    posn, posn_nxt;
    logic          sck_q, sample_q, sof_q, ready_q, valid_q, overrun_q;
    logic          sof_nxt, frame_end, new_ovr;

    assign frame_end = (div_cnt == DIV_LAST) && (posn == 6'd63);
    assign new_ovr   = ready_q && valid_q && !bus.ack;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en) state_nxt = RUN;
            RUN:     if (!bus.en) state_nxt = DRAIN;
            DRAIN: begin
                if (bus.en)         state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next divider/position; registered outputs are derived from these so they line up with div_cnt.
    always_comb begin
        div_nxt  = '0;
        posn_nxt = '0;
        sof_nxt  = 1'b0;
        if (state != IDLE && state_nxt != IDLE) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt  = '0;
                posn_nxt = posn + 6'd1;
                sof_nxt  = (posn == 6'd63);
            end else begin
                div_nxt  = div_cnt + DW'(1);
                posn_nxt = posn;
            end
        end else if (state == IDLE && state_nxt == RUN) begin
            sof_nxt = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            posn      <= '0;
            sck_q     <= 1'b0;
            sample_q  <= 1'b0;
            sof_q     <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            posn     <= posn_nxt;
            sck_q    <= (div_nxt >= DIV_HALF);
            sample_q <= (div_nxt == DIV_HALF);
            sof_q    <= sof_nxt;
            ready_q  <= sample_q && (posn == EOW_RIGHT);
            if (ready_q)      valid_q <= 1'b1;
            else if (bus.ack) valid_q <= 1'b0;
            if (new_ovr)          overrun_q <= 1'b1;
            else if (bus.clr_ovr) overrun_q <= 1'b0;
        end
    end

    assign bus.sck        = sck_q;
    assign bus.ws         = posn[5];
    assign bus.sample     = sample_q;
    assign bus.frame_posn = posn;
    assign bus.sof        = sof_q;
    assign bus.ready      = ready_q;
    assign bus.valid      = valid_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: time-based frame model compared every cycle,
// plus literal checkpoints for startup, ready timing, handshake, drain and async reset.
module tb_i2s_frame_ctrl;
    localparam int DIV   = 8;
    localparam int BITS  = 16;
    localparam int FRAME = 64 * DIV;
    localparam int RDY_T = (33 + BITS) * DIV + DIV / 2 + 1;

    logic ck = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    i2s_frame_ctrl_if bus ();
    i2s_frame_ctrl #(.DIV(DIV), .BITS(BITS)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));

    always #5 ck = ~ck;

    // Model: m_t counts ck cycles since the run started; everything else follows arithmetically.
    bit m_act, m_drain, m_valid, m_ovr;
    int m_t;

    function automatic bit m_ready();
        return m_act && ((m_t % FRAME) == RDY_T);
    endfunction

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 0; m_drain <= 0; m_t <= 0; m_valid <= 0; m_ovr <= 0;
        end else begin
            if (m_ready())     m_valid <= 1;
            else if (bus.ack)  m_valid <= 0;
            if (m_ready() && m_valid && !bus.ack) m_ovr <= 1;
            else if (bus.clr_ovr)                 m_ovr <= 0;
            if (m_act) begin
                if (m_drain && !bus.en && (m_t % FRAME) == FRAME - 1) begin
                    m_act <= 0; m_drain <= 0; m_t <= 0;
                end else begin
                    m_t <= m_t + 1; m_drain <= !bus.en;
                end
            end else if (bus.en) begin
                m_act <= 1; m_t <= 0; m_drain <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (rst_n) begin
            chk("m_sck",    32'(bus.sck),        32'(m_act && (m_t % DIV) >= DIV / 2));
            chk("m_sample", 32'(bus.sample),     32'(m_act && (m_t % DIV) == DIV / 2));
            chk("m_posn",   32'(bus.frame_posn), m_act ? 32'((m_t / DIV) % 64) : 32'd0);
            chk("m_ws",     32'(bus.ws),         32'(m_act && ((m_t / DIV) % 64) >= 32));
            chk("m_sof",    32'(bus.sof),        32'(m_act && (m_t % FRAME) == 0));
            chk("m_ready",  32'(bus.ready),      32'(m_ready()));
            chk("m_valid",  32'(bus.valid),      32'(m_valid));
            chk("m_ovr",    32'(bus.overrun),    32'(m_ovr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic wait_posn(input int p);
        int n;
        n = 0;
        do begin
            @(negedge ck);
            n++;
        end while (bus.frame_posn != 6'(p) && n < 1100);
        if (bus.frame_posn != 6'(p)) begin
            checks++; errors++;
            $display("FAIL wait_posn: got %0d expected %0d (timeout)", bus.frame_posn, p);
        end
    endtask

    initial begin
        bus.en = 0; bus.ack = 0; bus.clr_ovr = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_sck", 32'(bus.sck), 0);
        chk("rst_posn", 32'(bus.frame_posn), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        tick(2);
        rst_n = 1;
        tick(3);
        chk("idle_sck", 32'(bus.sck), 0);

        bus.en = 1;
        tick(1);
        chk("start_sof", 32'(bus.sof), 1);
        chk("start_sck", 32'(bus.sck), 0);
        tick(4);
        chk("d4_sample", 32'(bus.sample), 1);
        chk("d4_sck", 32'(bus.sck), 1);
        tick(3);
        chk("d7_sck", 32'(bus.sck), 1);
        chk("d7_posn", 32'(bus.frame_posn), 0);
        tick(1);
        chk("p1_sck", 32'(bus.sck), 0);
        chk("p1_posn", 32'(bus.frame_posn), 1);

        tick(389);
        chk("rdy1", 32'(bus.ready), 1);
        chk("rdy1_posn", 32'(bus.frame_posn), 49);
        chk("rdy1_ws", 32'(bus.ws), 1);
        chk("rdy1_valid", 32'(bus.valid), 0);
        tick(1);
        chk("f1_valid", 32'(bus.valid), 1);

        tick(511);
        chk("rdy2", 32'(bus.ready), 1);
        tick(1);
        chk("f2_ovr", 32'(bus.overrun), 1);
        chk("f2_valid", 32'(bus.valid), 1);
        bus.clr_ovr = 1;
        tick(1);
        bus.clr_ovr = 0;
        chk("clr_ovr", 32'(bus.overrun), 0);
        chk("clr_valid", 32'(bus.valid), 1);

        tick(510);
        chk("rdy3", 32'(bus.ready), 1);
        bus.ack = 1;
        tick(1);
        chk("coack_valid", 32'(bus.valid), 1);
        chk("coack_ovr", 32'(bus.overrun), 0);
        tick(1);
        bus.ack = 0;
        chk("ack_valid", 32'(bus.valid), 0);

        wait_posn(10);
        bus.en = 0;
        wait_posn(40);
        bus.en = 1;
        wait_posn(10);
        bus.en = 0;
        wait_posn(63);
        wait_posn(0);
        chk("drain_sof", 32'(bus.sof), 0);
        tick(6);
        chk("drain_sck", 32'(bus.sck), 0);
        chk("drain_posn", 32'(bus.frame_posn), 0);

        bus.en = 1;
        wait_posn(20);
        tick(4);
        chk("pre_rst_sck", 32'(bus.sck), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_sck", 32'(bus.sck), 0);
        chk("arst_sample", 32'(bus.sample), 0);
        chk("arst_posn", 32'(bus.frame_posn), 0);
        chk("arst_ws", 32'(bus.ws), 0);
        chk("arst_ready", 32'(bus.ready), 0);
        bus.en = 0;
        tick(2);
        rst_n = 1;
        tick(10);
        chk("post_rst_posn", 32'(bus.frame_posn), 0);
        chk("post_rst_sck", 32'(bus.sck), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
